fifo_uart_tx: RTL and testbench

//  Drains bytes from the FIFO read side and serialises each one as an 8N1 UART frame on a single TX line.

---
 rtl/fifo_uart_tx_pkg.sv | 21 ++
 rtl/fifo_uart_tx_baud_tick.sv | 37 +++
 rtl/fifo_uart_tx.sv | 151 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg
//   Shared definitions for the FIFO-fed UART transmitter and for the UART
//   receiver on the echo path.
//   - tx_state_e         : transmitter FSM state encoding (IDLE=0 .. STOP=5)
//   - calc_clks_per_bit(): CLK cycles per serial bit, truncated
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_FETCH = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } tx_state_e;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// fifo_uart_tx_baud_tick
//   Bit-period counter. Counts 0 .. CLKS_PER_BIT-1 and wraps to 0.
// Ports
//   clk_i    system clock
//   rst_ni   synchronous reset, active low
//   clr_i    hold the counter at 0
//   tick_o   high on the last clock of a bit period (count == CLKS_PER_BIT-1)
//   pre_o    high on the clock before tick_o (count == CLKS_PER_BIT-2)
module fifo_uart_tx_baud_tick
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o,
  output logic pre_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign pre_o  = (cnt_q == CW'(CLKS_PER_BIT - 2));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Pops bytes from a same-clock FIFO (1-cycle read latency) and sends each
//   one as an 8N1 UART frame, LSB first. All outputs are registered.
// Ports
//   CLK    system clock
//   RST    synchronous reset, active low
//   en     allow new frames to start (sampled in IDLE only)
//   empty  FIFO empty flag (sampled in IDLE only)
//   din    FIFO read data, valid the cycle after rReq
//   rReq   FIFO read strobe, one pulse per byte
//   tx     serial line, idle high
//   busy   high whenever the FSM is not in IDLE
//   done   one-cycle pulse on the last clock of the stop bit
//
// state   | meaning
// IDLE    | line high, waiting for en && !empty
// REQ     | rReq high for one clock
// FETCH   | FIFO drives din; captured at the end of this clock
// START   | start bit (low)
// DATA    | WL data bits, LSB first
// STOP    | stop bit (high), done on its last clock
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int WL       = 8,
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          en,
  input  logic          empty,
  input  logic [WL-1:0] din,
  output logic          rReq,
  output logic          tx,
  output logic          busy,
  output logic          done
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam int BCW          = $clog2(CLKS_PER_BIT);
  localparam int BITW         = $clog2(WL) + 1;

  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("fifo_uart_tx: CLK_FREQ/BAUD must be at least 2");
  end

  tx_state_e       state_q, state_d;
  logic [WL-1:0]   shift_q, shift_d;
  logic [BITW-1:0] bit_q, bit_d;
  logic            tx_q, tx_d;
  logic            rreq_q, rreq_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            baud_clr, baud_tick, baud_pre;

  fifo_uart_tx_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CW           (BCW)
  ) u_baud (
    .clk_i  (CLK),
    .rst_ni (RST),
    .clr_i  (baud_clr),
    .tick_o (baud_tick),
    .pre_o  (baud_pre)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rreq_d   = 1'b0;
    done_d   = 1'b0;
    baud_clr = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (en && !empty) begin
          state_d = S_REQ;
          rreq_d  = 1'b1;
        end
      end
      S_REQ: state_d = S_FETCH;
      S_FETCH: begin
        shift_d = din;
        bit_d   = '0;
        tx_d    = 1'b0;
        state_d = S_START;
      end
      S_START: begin
        baud_clr = 1'b0;
        if (baud_tick) begin
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        baud_clr = 1'b0;
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BITW'(1);
          if (bit_q == BITW'(WL - 1)) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            tx_d = shift_d[0];
          end
        end
      end
      S_STOP: begin
        baud_clr = 1'b0;
        // Registered done: raise it one clock early so it lands on the
        // final clock of the stop bit.
        if (baud_pre) done_d = 1'b1;
        if (baud_tick) begin
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      rreq_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rreq_q  <= rreq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rReq = rreq_q;
  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with CLK_FREQ=100, BAUD=10 (10 clocks per bit).
// The model describes each frame as a function of the number of edges since
// the edge that accepted it: rReq at offset 0, tx low from offset 2, one
// 10-clock slot per frame bit, done at the last clock of the frame.
module tb_fifo_uart_tx;

  localparam int WL = 8;
  localparam int C  = 10;
  localparam int F  = (WL + 2) * C;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       en  = 1'b0;
  logic       empty = 1'b1;
  logic [7:0] din = 8'h00;
  logic       rReq, tx, busy, done;

  always #5 CLK = ~CLK;

  fifo_uart_tx #(.WL(WL), .CLK_FREQ(100), .BAUD(10)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .en    (en),
    .empty (empty),
    .din   (din),
    .rReq  (rReq),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  // Byte store: the stimulus appends, the FIFO model and the frame model
  // each keep their own read index.
  logic [7:0] push_mem [0:31];
  int push_wr = 0;
  int fifo_rd = 0;
  int m_rd    = 0;

  int cyc = 0, rreq_cnt = 0, done_cnt = 0;
  bit m_active = 1'b0;
  int m_k = 0;
  logic [7:0] m_byte = 8'h00;
  logic e_tx = 1'b1, e_rreq = 1'b0, e_busy = 1'b0, e_done = 1'b0;

  int cmp_n = 0, err_n = 0;

  always @(posedge CLK) begin : model
    int k, b;
    bit act;
    logic [7:0] bv;
    k = m_k; act = m_active; bv = m_byte;
    if (!RST) act = 1'b0;
    else if (act) begin
      k = k + 1;
      if (k >= F + 2) act = 1'b0;
    end else if (en && !empty && m_rd != push_wr) begin
      act = 1'b1;
      k   = 0;
      bv  = push_mem[m_rd];
      m_rd <= m_rd + 1;
    end
    if (!act) begin
      e_tx <= 1'b1; e_rreq <= 1'b0; e_busy <= 1'b0; e_done <= 1'b0;
    end else begin
      e_rreq <= (k == 0);
      e_busy <= 1'b1;
      e_done <= (k == F + 1);
      if (k < 2) e_tx <= 1'b1;
      else begin
        b = (k - 2) / C;
        if (b == 0)       e_tx <= 1'b0;
        else if (b <= WL) e_tx <= bv[b-1];
        else              e_tx <= 1'b1;
      end
    end
    m_k <= k; m_active <= act; m_byte <= bv;

    cyc <= cyc + 1;
    if (rReq) rreq_cnt <= rreq_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (rReq && fifo_rd != push_wr) begin
      din     <= push_mem[fifo_rd];
      fifo_rd <= fifo_rd + 1;
      empty   <= (fifo_rd + 1 == push_wr);
    end else begin
      empty <= (fifo_rd == push_wr);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Every advance of time goes through here, so the model is compared on
  // every cycle.
  task automatic step();
    @(negedge CLK);
    check("model_tx",   {31'd0, tx},   {31'd0, e_tx});
    check("model_rreq", {31'd0, rReq}, {31'd0, e_rreq});
    check("model_busy", {31'd0, busy}, {31'd0, e_busy});
    check("model_done", {31'd0, done}, {31'd0, e_done});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input logic [7:0] b);
    push_mem[push_wr] = b;
    push_wr = push_wr + 1;
  endtask

  // which: 0 = tx low, 1 = done high, 2 = rReq high
  task automatic wait_for(input int which, input int maxc, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      step();
      if ((which == 0 && tx == 1'b0) || (which == 1 && done == 1'b1) ||
          (which == 2 && rReq == 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
    check(nm, {31'd0, ok}, 32'd1);
  endtask

  // pat[i] is the i-th line level of the frame (start, 8 data, stop).
  task automatic check_frame(input logic [9:0] pat, input string nm, output int t_done);
    int t0;
    wait_for(0, 60, {nm, "_start_timeout"});
    t0 = cyc;
    steps(5);
    for (int i = 0; i < 10; i++) begin
      check({nm, "_bit"}, {31'd0, tx}, {31'd0, pat[i]});
      if (i < 9) steps(10);
    end
    wait_for(1, 20, {nm, "_done_timeout"});
    t_done = cyc;
    check({nm, "_done_offset"}, t_done - t0, 32'd99);
  endtask

  initial begin
    int c0, d0, td, tr;

    // 1: reset with data available
    RST = 1'b0; en = 1'b1;
    push(8'hA5);
    c0 = rreq_cnt;
    steps(3);
    check("rst_tx",   {31'd0, tx},   32'd1);
    check("rst_rreq", {31'd0, rReq}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    RST = 1'b1;
    step();
    check("first_rreq", {31'd0, rReq}, 32'd1);

    // 2: single byte 0xA5
    check_frame(10'b1101001010, "a5", td);
    step();
    check("a5_busy_drop", {31'd0, busy}, 32'd0);
    check("a5_rreq_count", rreq_cnt - c0, 32'd1);

    // 3: empty FIFO
    c0 = rreq_cnt;
    steps(200);
    check("empty_rreq_count", rreq_cnt - c0, 32'd0);
    check("empty_tx",   {31'd0, tx},   32'd1);
    check("empty_busy", {31'd0, busy}, 32'd0);

    // 4: back-to-back 0x00, 0xFF
    c0 = rreq_cnt;
    push(8'h00); push(8'hFF);
    check_frame(10'b1000000000, "b00", td);
    wait_for(2, 10, "b2b_rreq_timeout");
    tr = cyc;
    check("b2b_gap", tr - td, 32'd2);
    check_frame(10'b1111111110, "bff", td);
    steps(3);
    check("b2b_rreq_count", rreq_cnt - c0, 32'd2);

    // 5: reset in data bit 3 of 0x3C, then 0x5A intact
    push(8'h3C); push(8'h5A);
    wait_for(0, 20, "rst_mid_start_timeout");
    steps(45);
    RST = 1'b0;
    step();
    check("midrst_tx",   {31'd0, tx},   32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    d0 = done_cnt;
    RST = 1'b1;
    check_frame(10'b1010110100, "b5a", td);
    step();
    check("midrst_done_count", done_cnt - d0, 32'd1);

    // 6: en dropped during START with 3 bytes queued
    steps(5);
    push(8'h11); push(8'h22); push(8'h33);
    wait_for(0, 20, "en_start_timeout");
    en = 1'b0;
    c0 = rreq_cnt;
    wait_for(1, 120, "en_done_timeout");
    steps(200);
    check("en_off_rreq_count", rreq_cnt - c0, 32'd0);
    check("en_off_busy", {31'd0, busy}, 32'd0);
    check("en_off_tx",   {31'd0, tx},   32'd1);
    en = 1'b1;
    check_frame(10'b1001000100, "b22", td);
    check_frame(10'b1001100110, "b33", td);
    steps(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
